stim_gen_nch: RTL and testbench



---
 rtl/stim_gen_nch_pkg.sv | 29 ++
 rtl/stim_gen_nch_lane.sv | 147 ++++++++++++++
 rtl/stim_gen_nch.sv | 75 +++++++
 tb/tb_stim_gen_nch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_gen_nch_pkg.sv
// Purpose : shared constants, checker state type and PRBS7 helper for the stimulus generator.
// Latency : n/a (declarations only).
// Backpr.  : n/a.
package stim_pkg;

  localparam logic [7:0] MODE_OFF      = 8'd0;
  localparam logic [7:0] MODE_STATIC   = 8'd1;
  localparam logic [7:0] MODE_TOGGLE   = 8'd2;
  localparam logic [7:0] MODE_PRBS     = 8'd3;
  localparam logic [7:0] MODE_PRBS_INV = 8'd4;

  // x^7 + x^6 + 1: feedback is the XOR of bits 6 and 5
  localparam logic [6:0] PRBS7_TAP = 7'h60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAP)};
  endfunction

  function automatic logic mode_is_pattern(input logic [7:0] m);
    return (m >= MODE_TOGGLE) && (m <= MODE_PRBS_INV);
  endfunction

endpackage

// File: rtl/stim_gen_nch_lane.sv
// Purpose : one lane - pattern generator, DOUT history, loopback latency search/lock, bit/error counters.
// Latency : DOUT/DOE one cycle after main_mode is sampled; counters update one cycle after DIN.
// Backpr.  : none; free-running, DIN is sampled every cycle.
// Ports   : clr restarts the lane; din is the looped-back bit; dout/doe drive the pad;
//           locked/lat report the lock; recv_cnt/err_cnt are saturating counters.
module stim_lane
  import stim_pkg::*;
#(
  parameter int         CNT_W   = 30,
  parameter int         LAT_MAX = 15,
  parameter int         LOCK_N  = 16,
  parameter logic [6:0] SEED    = 7'h7E,
  parameter bit         INV     = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic [7:0]       main_mode,
  input  logic             static_lvl,
  input  logic             din,
  output logic             dout,
  output logic             doe,
  output logic             locked,
  output logic [3:0]       lat,
  output logic [CNT_W-1:0] recv_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int              MC_W    = $clog2(LOCK_N + 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_N - 1);
  localparam logic [3:0]      L_LAST  = 4'(LAT_MAX);

  chk_state_t       state_q, state_d;
  logic [3:0]       l_q, l_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [3:0]       lat_q, lat_d;
  logic [CNT_W-1:0] recv_q, recv_d, err_q, err_d;
  logic [6:0]       lfsr_q, lfsr_d, lfsr_src;
  logic             tog_q, tog_d, tog_src;
  logic             dout_d, doe_q, doe_d;
  // hist_q[0] is the DOUT register itself; hist_q[k] is DOUT k cycles ago
  logic [LAT_MAX:0] hist_q;

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    mc_d     = mc_q;
    lat_d    = lat_q;
    recv_d   = recv_q;
    err_d    = err_q;
    dout_d   = 1'b0;
    doe_d    = 1'b0;
    // a clear restarts the generators from their initial state in this same cycle
    lfsr_src = clr ? SEED : lfsr_q;
    tog_src  = clr ? 1'b0 : tog_q;
    lfsr_d   = lfsr_src;
    tog_d    = tog_src;

    if (clr) begin
      recv_d = '0;
      err_d  = '0;
    end

    case (main_mode)
      MODE_STATIC: begin
        doe_d  = 1'b1;
        dout_d = static_lvl;
      end
      MODE_TOGGLE: begin
        doe_d  = 1'b1;
        dout_d = tog_src;
        tog_d  = ~tog_src;
      end
      MODE_PRBS, MODE_PRBS_INV: begin
        doe_d  = 1'b1;
        dout_d = lfsr_src[6] ^ (INV & (main_mode == MODE_PRBS_INV));
        lfsr_d = prbs7_step(lfsr_src);
      end
      default: ;
    endcase

    if (!mode_is_pattern(main_mode)) begin
      state_d = IDLE;
    end else if (clr || (state_q == IDLE)) begin
      state_d = SEEK;
      l_d     = '0;
      mc_d    = '0;
    end else begin
      case (state_q)
        SEEK: begin
          if (din == hist_q[l_q]) begin
            mc_d = mc_q + 1'b1;
            if (mc_q == MC_LAST) begin
              state_d = LOCKED;
              lat_d   = l_q;
            end
          end else begin
            mc_d = '0;
            l_d  = (l_q == L_LAST) ? 4'd0 : l_q + 4'd1;
          end
        end
        LOCKED: begin
          // no unlock path: errors are only counted
          recv_d = (&recv_q) ? recv_q : recv_q + 1'b1;
          if (din != hist_q[lat_q]) begin
            err_d = (&err_q) ? err_q : err_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      l_q     <= '0;
      mc_q    <= '0;
      lat_q   <= '0;
      recv_q  <= '0;
      err_q   <= '0;
      lfsr_q  <= SEED;
      tog_q   <= 1'b0;
      doe_q   <= 1'b0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      mc_q    <= mc_d;
      lat_q   <= lat_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      lfsr_q  <= lfsr_d;
      tog_q   <= tog_d;
      doe_q   <= doe_d;
      hist_q  <= {hist_q[LAT_MAX-1:0], dout_d};
    end
  end

  assign dout     = hist_q[0];
  assign doe      = doe_q;
  assign locked   = (state_q == LOCKED);
  assign lat      = lat_q;
  assign recv_cnt = recv_q;
  assign err_cnt  = err_q;

endmodule

// File: rtl/stim_gen_nch.sv
// Purpose : NCH-lane stimulus generator with loopback latency lock and BER counters.
// Latency : DOUT/DOE one cycle after MAIN_MODE; PHY_INIT one cycle after the last lane locks.
// Backpr.  : none; all lanes free-run on CLK.
// Ports   : CLK/RST (sync, active-high), CLR restart, MAIN_MODE/SUB_MODE mode select,
//           DOUT/DOE/DIN per lane, PHY_INIT all-locked, LAT/RECV_CNT/ERR_CNT packed per lane.
module stim_gen_nch
  import stim_pkg::*;
#(
  parameter int         NCH       = 2,
  parameter int         CNT_W     = 30,
  parameter int         LAT_MAX   = 15,
  parameter int         LOCK_N    = 16,
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic [7:0]           MAIN_MODE,
  input  logic [7:0]           SUB_MODE,
  output logic [NCH-1:0]       DOUT,
  output logic [NCH-1:0]       DOE,
  input  logic [NCH-1:0]       DIN,
  output logic                 PHY_INIT,
  output logic [4*NCH-1:0]     LAT,
  output logic [CNT_W*NCH-1:0] RECV_CNT,
  output logic [CNT_W*NCH-1:0] ERR_CNT
);

  logic [7:0]     mode_q;
  logic           phy_q;
  logic           clr;
  logic [NCH-1:0] locked;
  logic           unused_sub;

  // any mode change restarts every lane exactly like CLR
  assign clr        = CLR | (MAIN_MODE != mode_q);
  assign unused_sub = ^SUB_MODE[7:1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= MODE_OFF;
      phy_q  <= 1'b0;
    end else begin
      mode_q <= MAIN_MODE;
      // a clear drops lock in the next cycle, so it must mask PHY_INIT as well
      phy_q  <= ~clr & (&locked);
    end
  end

  assign PHY_INIT = phy_q;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
    stim_lane #(
      .CNT_W   (CNT_W),
      .LAT_MAX (LAT_MAX),
      .LOCK_N  (LOCK_N),
      .SEED    (PRBS_SEED ^ 7'(ch + 1)),
      .INV     ((ch % 2) == 1)
    ) u_lane (
      .CLK        (CLK),
      .RST        (RST),
      .clr        (clr),
      .main_mode  (MAIN_MODE),
      .static_lvl (SUB_MODE[0]),
      .din        (DIN[ch]),
      .dout       (DOUT[ch]),
      .doe        (DOE[ch]),
      .locked     (locked[ch]),
      .lat        (LAT[4*ch +: 4]),
      .recv_cnt   (RECV_CNT[CNT_W*ch +: CNT_W]),
      .err_cnt    (ERR_CNT[CNT_W*ch +: CNT_W])
    );
  end

endmodule

// File: tb/tb_stim_gen_nch.sv
module tb_stim_gen_nch;

  localparam int         NCH       = 2;
  localparam int         CNT_W     = 30;
  localparam int         LAT_MAX   = 15;
  localparam int         LOCK_N    = 16;
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  localparam longint     CMAX      = (64'd1 << CNT_W) - 1;
  localparam int         LOCK_BUDGET = (LAT_MAX + 1) * (LOCK_N + 1);

  logic                 CLK = 1'b0;
  logic                 RST, CLR;
  logic [7:0]           MAIN_MODE, SUB_MODE;
  logic [NCH-1:0]       DOUT, DOE, DIN;
  logic                 PHY_INIT;
  logic [4*NCH-1:0]     LAT;
  logic [CNT_W*NCH-1:0] RECV_CNT, ERR_CNT;

  always #5 CLK = ~CLK;

  stim_gen_nch #(.NCH(NCH), .CNT_W(CNT_W), .LAT_MAX(LAT_MAX), .LOCK_N(LOCK_N), .PRBS_SEED(PRBS_SEED)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .MAIN_MODE(MAIN_MODE), .SUB_MODE(SUB_MODE),
    .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .PHY_INIT(PHY_INIT), .LAT(LAT),
    .RECV_CNT(RECV_CNT), .ERR_CNT(ERR_CNT));

  // narrow-counter instance with a direct-wire loopback, held in PRBS mode throughout
  logic       s_clr = 1'b0;
  logic [7:0] s_mode = 8'd3, s_sub = 8'd0;
  logic [0:0] s_dout, s_doe, s_din;
  logic       s_phy;
  logic [3:0] s_lat, s_recv, s_err;
  assign s_din = s_dout;

  stim_gen_nch #(.NCH(1), .CNT_W(4)) u_sat (
    .CLK(CLK), .RST(RST), .CLR(s_clr), .MAIN_MODE(s_mode), .SUB_MODE(s_sub),
    .DOUT(s_dout), .DOE(s_doe), .DIN(s_din), .PHY_INIT(s_phy), .LAT(s_lat),
    .RECV_CNT(s_recv), .ERR_CNT(s_err));

  int total = 0;
  int bad   = 0;

  // reference model: pattern index since restart, DOUT history, checker by the stated rules
  bit     prbs_seq[NCH][127];
  int     m_mode_prev;
  int     m_n[NCH];
  bit     m_hist[NCH][LAT_MAX+1];
  bit     m_doe[NCH];
  int     m_st[NCH];             // 0 idle, 1 seeking, 2 locked
  int     m_l[NCH], m_mc[NCH], m_lat[NCH];
  longint m_recv[NCH], m_err[NCH];
  bit     m_phy;
  int     dly[NCH];
  bit     flip[NCH];
  bit     din_stuck0 = 1'b0;

  function automatic longint sat_inc(input longint v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [NCH-1:0] exp_dout();
    logic [NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = m_hist[ch][0];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_doe();
    logic [NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = m_doe[ch];
    return v;
  endfunction

  function automatic logic [4*NCH-1:0] exp_lat();
    logic [4*NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[4*ch +: 4] = 4'(m_lat[ch]);
    return v;
  endfunction

  function automatic logic [CNT_W*NCH-1:0] exp_recv();
    logic [CNT_W*NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[CNT_W*ch +: CNT_W] = CNT_W'(m_recv[ch]);
    return v;
  endfunction

  function automatic logic [CNT_W*NCH-1:0] exp_err();
    logic [CNT_W*NCH-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[CNT_W*ch +: CNT_W] = CNT_W'(m_err[ch]);
    return v;
  endfunction

  // drive DIN from the model's DOUT history, advance the model over one edge, wait for the edge
  task automatic step();
    bit clr, act, all_locked, d, e;
    int md;
    for (int ch = 0; ch < NCH; ch++)
      DIN[ch] = din_stuck0 ? 1'b0 : (m_hist[ch][dly[ch]] ^ flip[ch]);
    md = int'(MAIN_MODE);
    if (RST) begin
      m_mode_prev = 0;
      m_phy = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        m_n[ch] = 0; m_doe[ch] = 1'b0; m_st[ch] = 0; m_l[ch] = 0; m_mc[ch] = 0;
        m_lat[ch] = 0; m_recv[ch] = 0; m_err[ch] = 0;
        for (int k = 0; k <= LAT_MAX; k++) m_hist[ch][k] = 1'b0;
      end
    end else begin
      clr = CLR || (md != m_mode_prev);
      m_mode_prev = md;
      act = (md >= 2) && (md <= 4);
      all_locked = 1'b1;
      for (int ch = 0; ch < NCH; ch++) if (m_st[ch] != 2) all_locked = 1'b0;
      m_phy = !clr && all_locked;
      for (int ch = 0; ch < NCH; ch++) begin
        if (clr) begin m_recv[ch] = 0; m_err[ch] = 0; end
        if (!act) m_st[ch] = 0;
        else if (clr || m_st[ch] == 0) begin m_st[ch] = 1; m_l[ch] = 0; m_mc[ch] = 0; end
        else if (m_st[ch] == 1) begin
          if (DIN[ch] == m_hist[ch][m_l[ch]]) begin
            m_mc[ch]++;
            if (m_mc[ch] == LOCK_N) begin m_st[ch] = 2; m_lat[ch] = m_l[ch]; end
          end else begin
            m_mc[ch] = 0;
            m_l[ch] = (m_l[ch] == LAT_MAX) ? 0 : m_l[ch] + 1;
          end
        end else begin
          m_recv[ch] = sat_inc(m_recv[ch]);
          if (DIN[ch] != m_hist[ch][m_lat[ch]]) m_err[ch] = sat_inc(m_err[ch]);
        end
        if (clr) m_n[ch] = 0;
        d = 1'b0; e = 1'b0;
        case (md)
          1: begin d = SUB_MODE[0]; e = 1'b1; end
          2: begin d = m_n[ch] % 2; e = 1'b1; m_n[ch] = (m_n[ch] + 1) % 254; end
          3, 4: begin
            d = prbs_seq[ch][m_n[ch] % 127] ^ ((md == 4) && (ch % 2 == 1));
            e = 1'b1; m_n[ch] = (m_n[ch] + 1) % 254;
          end
          default: ;
        endcase
        for (int k = LAT_MAX; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = d;
        m_doe[ch] = e;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    MAIN_MODE = 8'd3; SUB_MODE = 8'd0; CLR = 1'b0; RST = 1'b1;
    step(); step();
    total++; if (DOUT !== '0) begin bad++; $display("FAIL reset_dout got=%b want=0", DOUT); end
    total++; if (DOE !== '0) begin bad++; $display("FAIL reset_doe got=%b want=0", DOE); end
    total++; if (PHY_INIT !== 1'b0) begin bad++; $display("FAIL reset_phy got=%b want=0", PHY_INIT); end
    total++; if (RECV_CNT !== '0 || ERR_CNT !== '0) begin bad++; $display("FAIL reset_cnt recv=%h err=%h want=0", RECV_CNT, ERR_CNT); end
    total++; if (LAT !== '0) begin bad++; $display("FAIL reset_lat got=%h want=0", LAT); end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (DOUT !== exp_dout() || DOE !== '1) begin
        bad++; $display("FAIL prbs_start cyc=%0d dout=%b doe=%b want dout=%b doe=11", i, DOUT, DOE, exp_dout());
      end
    end
  endtask

  task automatic test_static();
    MAIN_MODE = 8'd1; SUB_MODE = 8'd1;
    step();
    total++; if (DOUT !== '1 || DOE !== '1) begin bad++; $display("FAIL static_out dout=%b doe=%b want 11/11", DOUT, DOE); end
    for (int i = 0; i < 40; i++) begin
      step();
      total++; if (PHY_INIT !== 1'b0) begin bad++; $display("FAIL static_phy cyc=%0d got=%b want=0", i, PHY_INIT); end
    end
    total++; if (RECV_CNT !== '0) begin bad++; $display("FAIL static_recv got=%h want=0", RECV_CNT); end
  endtask

  task automatic wait_lock(input string tag);
    for (int c = 0; c < LOCK_BUDGET; c++) begin
      if (PHY_INIT === 1'b1) break;
      step();
    end
    total++;
    if (PHY_INIT !== 1'b1) begin bad++; $display("FAIL %s_lock_timeout phy=%b want=1 within %0d", tag, PHY_INIT, LOCK_BUDGET); end
  endtask

  task automatic test_prbs_lock();
    dly[0] = 3; dly[1] = 5;
    MAIN_MODE = 8'd3;
    wait_lock("prbs");
    total++; if (LAT !== {4'd5, 4'd3}) begin bad++; $display("FAIL prbs_lat got=%h want=53", LAT); end
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (RECV_CNT !== exp_recv() || ERR_CNT !== '0) begin
        bad++; $display("FAIL prbs_count cyc=%0d recv=%h err=%h want recv=%h err=0", i, RECV_CNT, ERR_CNT, exp_recv());
      end
    end
  endtask

  task automatic test_err_inject();
    flip[1] = 1'b1; step(); flip[1] = 1'b0; step();
    total++;
    if (ERR_CNT[CNT_W +: CNT_W] !== CNT_W'(1) || ERR_CNT[0 +: CNT_W] !== '0) begin
      bad++; $display("FAIL err_inject err=%h want lane1=1 lane0=0", ERR_CNT);
    end
    total++; if (PHY_INIT !== 1'b1) begin bad++; $display("FAIL err_phy got=%b want=1", PHY_INIT); end
  endtask

  task automatic test_clear_and_mode();
    CLR = 1'b1; step(); CLR = 1'b0;
    total++;
    if (RECV_CNT !== '0 || ERR_CNT !== '0 || PHY_INIT !== 1'b0) begin
      bad++; $display("FAIL clr_restart recv=%h err=%h phy=%b want 0/0/0", RECV_CNT, ERR_CNT, PHY_INIT);
    end
    wait_lock("clr");
    total++; if (LAT !== {4'd5, 4'd3}) begin bad++; $display("FAIL clr_lat got=%h want=53", LAT); end
    MAIN_MODE = 8'd4; step();
    total++;
    if (RECV_CNT !== '0 || ERR_CNT !== '0 || PHY_INIT !== 1'b0) begin
      bad++; $display("FAIL mode4_restart recv=%h err=%h phy=%b want 0/0/0", RECV_CNT, ERR_CNT, PHY_INIT);
    end
    total++; if (DOUT !== exp_dout()) begin bad++; $display("FAIL mode4_dout got=%b want=%b", DOUT, exp_dout()); end
    wait_lock("mode4");
    for (int i = 0; i < 30; i++) step();
    total++; if (LAT !== {4'd5, 4'd3}) begin bad++; $display("FAIL mode4_lat got=%h want=53", LAT); end
    total++;
    if (ERR_CNT !== '0 || RECV_CNT !== exp_recv()) begin
      bad++; $display("FAIL mode4_count recv=%h err=%h want recv=%h err=0", RECV_CNT, ERR_CNT, exp_recv());
    end
  endtask

  task automatic test_saturation();
    total++; if (s_recv !== 4'hF) begin bad++; $display("FAIL sat_recv got=%0d want=15", s_recv); end
    total++; if (s_err !== 4'h0 || s_lat !== 4'h0) begin bad++; $display("FAIL sat_err_lat err=%0d lat=%0d want 0/0", s_err, s_lat); end
    total++; if (s_phy !== 1'b1) begin bad++; $display("FAIL sat_phy got=%b want=1", s_phy); end
  endtask

  task automatic test_no_lock();
    bit seen_phy = 1'b0;
    din_stuck0 = 1'b1;
    MAIN_MODE = 8'd3;
    for (int i = 0; i < 2 * LOCK_BUDGET; i++) begin
      step();
      if (PHY_INIT !== 1'b0) seen_phy = 1'b1;
    end
    total++; if (seen_phy) begin bad++; $display("FAIL nolock_phy got=1 want=0 throughout"); end
    total++; if (RECV_CNT !== '0) begin bad++; $display("FAIL nolock_recv got=%h want=0", RECV_CNT); end
    din_stuck0 = 1'b0;
  endtask

  task automatic test_random();
    logic [4*NCH-1:0] lat_mask;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        MAIN_MODE = 8'($urandom_range(0, 6));
        SUB_MODE  = 8'($urandom);
        for (int ch = 0; ch < NCH; ch++) dly[ch] = $urandom_range(0, LAT_MAX);
      end
      CLR = ($urandom_range(0, 199) == 0);
      RST = ($urandom_range(0, 999) == 0);
      for (int ch = 0; ch < NCH; ch++) flip[ch] = ($urandom_range(0, 99) == 0);
      step();
      // toggle lock lands on the first matching latency, so only its parity is meaningful
      lat_mask = (MAIN_MODE == 8'd2) ? {NCH{4'b0001}} : '1;
      total++;
      if (DOUT !== exp_dout() || DOE !== exp_doe()) begin
        bad++; $display("FAIL rnd_out cyc=%0d dout=%b doe=%b want %b/%b", i, DOUT, DOE, exp_dout(), exp_doe());
      end
      total++;
      if (PHY_INIT !== m_phy || (LAT & lat_mask) !== (exp_lat() & lat_mask)) begin
        bad++; $display("FAIL rnd_lock cyc=%0d phy=%b lat=%h want %b/%h", i, PHY_INIT, LAT, m_phy, exp_lat());
      end
      total++;
      if (RECV_CNT !== exp_recv() || ERR_CNT !== exp_err()) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d recv=%h err=%h want %h/%h", i, RECV_CNT, ERR_CNT, exp_recv(), exp_err());
      end
    end
    CLR = 1'b0; RST = 1'b0;
  endtask

  initial begin
    logic [6:0] s;
    for (int ch = 0; ch < NCH; ch++) begin
      s = PRBS_SEED ^ 7'(ch + 1);
      for (int k = 0; k < 127; k++) begin
        prbs_seq[ch][k] = s[6];
        s = {s[5:0], s[6] ^ s[5]};
      end
      dly[ch] = 0; flip[ch] = 1'b0;
      for (int k = 0; k <= LAT_MAX; k++) m_hist[ch][k] = 1'b0;
    end
    DIN = '0;
    test_reset();
    test_static();
    test_prbs_lock();
    test_err_inject();
    test_clear_and_mode();
    test_saturation();
    test_no_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
